// File: rtl/mul_nibble_seq.sv
// mul_nibble_seq: sequential WxW unsigned multiplier built around a single
// shared 4x4 multiplier core (bit4_mul). One nibble pair goes through the
// core per cycle, and the shifted partial products are summed into a 2W-bit
// accumulator. Operands arrive on a valid/ready handshake, and the product
// leaves on another.
//
// Optional build macro: MUL_NIBBLE_SEQ_ZERO_SKIP_EN
//   When defined, a zero operand at accept jumps straight to DONE with c=0
//   and the core is never used. When undefined, zero operands run the full
//   K*K cycles like any other operands.

// 4x4 unsigned combinational multiplier core.
module bit4_mul (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] c
);
    assign c = {4'b0000, a} * {4'b0000, b};
endmodule

module mul_nibble_seq #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] c,
    output logic           busy
);
    localparam int K  = W / 4;
    localparam int N  = K * K;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    generate
        if (W < 4 || (W % 4) != 0) begin : g_bad_width
            $error("mul_nibble_seq: W must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [2*W-1:0] acc;
    logic [IW-1:0]  idx;

    int             i_nib;
    int             j_nib;
    logic [3:0]     core_a;
    logic [3:0]     core_b;
    logic [7:0]     core_c;
    logic [2*W-1:0] pp;

    bit4_mul u_core (
        .a (core_a),
        .b (core_b),
        .c (core_c)
    );

    // Pick the current nibble pair and align the core's product by nibble weight.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        i_nib  = int'(idx) % K;
        j_nib  = int'(idx) / K;
        core_a = a_reg[4*i_nib +: 4];
        core_b = b_reg[4*j_nib +: 4];
        pp     = (2*W)'(core_c) << (4 * (i_nib + j_nib));
    end

    // Control FSM and datapath registers, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                        acc   <= '0;
                        idx   <= '0;
`ifdef MUL_NIBBLE_SEQ_ZERO_SKIP_EN
                        if (a == '0 || b == '0) state <= DONE;
                        else                    state <= RUN;
`else
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    acc <= acc + pp;
                    idx <= idx + 1'b1;
                    if (idx == LAST) state <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake flags are decoded from the registered state.
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign c         = acc;

endmodule

// File: doc/mul_nibble_seq.md
Name: mul_nibble_seq

Overview:
- Sequential W×W unsigned multiplier controller that time-shares one 4×4 combinational multiplier core (bit4_mul: a[3:0], b[3:0] -> c[7:0]), instantiated inside this block.
- Feeds nibble pairs through the core one per cycle and accumulates the shifted partial products into a 2W-bit result.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides; used where area matters more than latency.

Parameters:
- W, 8, operand width in bits; must be a multiple of 4 and ≥4 (otherwise `$error` at elaboration). K = W/4 nibbles per operand.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- a  input  W  multiplicand, unsigned
- b  input  W  multiplier, unsigned
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- c  output  2W  product a*b, unsigned
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst=1 at an edge), overriding everything:
  - state=IDLE, out_valid=0, c=0.
  - Internal operand registers, accumulator and index cleared.
  - Reset mid-RUN or mid-DONE aborts the operation; no result is emitted.
- States and combinational outputs:
  - IDLE, RUN, DONE.
  - in_ready = (state==IDLE). busy = (state!=IDLE). out_valid = (state==DONE).
- IDLE:
  - Accept on an edge with in_valid && in_ready.
  - On accept: latch a and b, clear the accumulator, idx=0, go to RUN.
  - c keeps the previous result until the accept edge clears it.
- RUN, one partial product per cycle:
  - i = idx mod K, j = idx div K.
  - Core inputs are a_reg[4i+3:4i] and b_reg[4j+3:4j].
  - acc <= acc + (core_out << 4(i+j)), full 2W-bit width; overflow is impossible.
  - idx increments each cycle.
  - At idx==K*K-1: perform the final accumulate and go to DONE.
- Latency:
  - Exactly K*K edges from the accept edge to out_valid=1.
  - W=8 gives 4 cycles; W=16 gives 16 cycles.
- DONE:
  - c = acc, held stable while out_valid && !out_ready.
  - Edge with out_ready=1: go to IDLE.
  - in_ready is not asserted in that same cycle, so there is no same-cycle result/operand overlap.
  - Next accept is possible one cycle later.
- Inputs outside accept:
  - in_valid while busy is ignored; a and b may change freely.
  - Operands are sampled only at the accept edge.
- out_ready in IDLE or RUN has no effect.
- K=1 (W=4): a single RUN cycle, latency 1.

Optional Feature:
- Macro: MUL_NIBBLE_SEQ_ZERO_SKIP_EN
- Defined:
  - At the accept edge, if a==0 or b==0, go directly IDLE -> DONE with acc=0.
  - out_valid is asserted one edge after accept (latency 1) and the core is not used.
  - Non-zero operands behave as in the base design.
- Undefined:
  - Zero operands take the full K*K cycles and give c=0.

Test Plan:
- W=8, a=0xFF, b=0xFF, out_ready=1 -> out_valid exactly 4 cycles after accept; c=0xFE01; in_ready=0 and busy=1 during those 4 cycles.
- W=8, a=0x12, b=0x34; hold out_ready=0 for 3 cycles in DONE, then 1 -> c=0x03A8 stable throughout; IDLE one cycle after the out_ready edge.
- W=8, accept 0x12×0x34; toggle a and b and keep in_valid=1 during RUN -> no second accept while busy; result still 0x03A8.
- W=8, accept 0xA5×0x5A; assert rst=1 for one edge in the second RUN cycle -> next cycle state IDLE, out_valid=0, c=0, in_ready=1; no result emitted.
- W=16, a=0xFFFF, b=0xFFFF -> c=0xFFFE0001 after 16 cycles.
- W=8, a=0x00, b=0xAB:
  - With MUL_NIBBLE_SEQ_ZERO_SKIP_EN: out_valid after 1 cycle, c=0.
  - Without it: after 4 cycles, c=0.
